uart_alu_bridge: RTL

- Device-side end of the UART link driven by uart_top: consumes the byte stream from the UART receiver and returns one result byte per command through the UART transmitter.
- A command is three bytes in order: operand A, operand B, opcode. The block executes the opcode on the internal ALU, then hands the result byte to the transmitter with a tx_start/tx_done handshake.
- Sits between uart_rx/uart_tx and the rest of the board; carries no baud logic.

---
 rtl/uart_alu_pkg.sv | 24 ++
 rtl/alu.sv | 42 ++++
 rtl/uart_alu_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU bridge.
//   - opcode constants (6-bit, MIPS-style funct encoding)
//   - FSM state encoding used by uart_alu_bridge
package uart_alu_pkg;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;

   typedef enum logic [2:0] {
      ST_A    = 3'd0,
      ST_B    = 3'd1,
      ST_OP   = 3'd2,
      ST_EXEC = 3'd3,
      ST_SEND = 3'd4,
      ST_WAIT = 3'd5
   } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the UART bridge.
// Ports:
//   A, B : operands (N_BITS)
//   OP   : opcode (N_OP)
//   RES  : result (N_BITS), unsigned wrap, no carry out; unknown opcode gives 0
module alu
   import uart_alu_pkg::*;
#(
   parameter int N_BITS = 8,
   parameter int N_OP   = 6
) (
   input  logic [N_BITS-1:0] A,
   input  logic [N_BITS-1:0] B,
   input  logic [N_OP-1:0]   OP,
   output logic [N_BITS-1:0] RES
);

   localparam int unsigned SHIFT_LIM = N_BITS;

   logic shift_ovf;

   // Shift amounts of N_BITS or more saturate explicitly rather than relying
   // on the shift operator's out-of-range behaviour.
   assign shift_ovf = (32'(B) >= SHIFT_LIM);

   always_comb begin
      RES = '0;
      case (OP)
         N_OP'(OP_ADD): RES = A + B;
         N_OP'(OP_SUB): RES = A - B;
         N_OP'(OP_AND): RES = A & B;
         N_OP'(OP_OR):  RES = A | B;
         N_OP'(OP_XOR): RES = A ^ B;
         N_OP'(OP_NOR): RES = ~(A | B);
         N_OP'(OP_SRA): RES = shift_ovf ? {N_BITS{A[N_BITS-1]}}
                                        : N_BITS'($signed(A) >>> B);
         N_OP'(OP_SRL): RES = shift_ovf ? '0 : (A >> B);
         default:       RES = '0;
      endcase
   end

endmodule

// File: rtl/uart_alu_bridge.sv
// Device-side UART command bridge: collects A, B, opcode bytes from the
// receiver, runs them through the ALU and returns one result byte to the
// transmitter with a tx_start / tx_done_tick handshake.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   rx_data        : received byte, valid with rx_done_tick
//   rx_done_tick   : receiver byte strobe
//   tx_done_tick   : transmitter finished strobe
//   tx_start       : pulse to start transmission of tx_data
//   tx_data        : result byte, held from tx_start until tx_done_tick
//   busy           : command in progress (opcode received .. tx done)
//   result_valid   : pulse when result register loads
//   overrun        : pulse when a byte is dropped because busy
//
// state   | meaning
// ST_A    | waiting for operand A
// ST_B    | waiting for operand B
// ST_OP   | waiting for opcode
// ST_EXEC | load ALU result
// ST_SEND | issue tx_start
// ST_WAIT | wait for transmitter done
module uart_alu_bridge
   import uart_alu_pkg::*;
#(
   parameter int N_BITS = 8,
   parameter int N_OP   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_BITS-1:0] rx_data,
   input  logic              rx_done_tick,
   input  logic              tx_done_tick,
   output logic              tx_start,
   output logic [N_BITS-1:0] tx_data,
   output logic              busy,
   output logic              result_valid,
   output logic              overrun
);

   state_t state, state_nx;

   logic [N_BITS-1:0] a_q, a_nx;
   logic [N_BITS-1:0] b_q, b_nx;
   logic [N_OP-1:0]   op_q, op_nx;
   logic [N_BITS-1:0] res_q, res_nx;
   logic [N_BITS-1:0] alu_res;
   logic [N_BITS-1:0] tx_data_nx;
   logic              tx_start_nx;
   logic              busy_nx;
   logic              result_valid_nx;
   logic              overrun_nx;

   alu #(
      .N_BITS (N_BITS),
      .N_OP   (N_OP)
   ) u_alu (
      .A   (a_q),
      .B   (b_q),
      .OP  (op_q),
      .RES (alu_res)
   );

   always_comb begin
      state_nx        = state;
      a_nx            = a_q;
      b_nx            = b_q;
      op_nx           = op_q;
      res_nx          = res_q;
      tx_data_nx      = tx_data;
      tx_start_nx     = 1'b0;
      result_valid_nx = 1'b0;
      overrun_nx      = 1'b0;

      case (state)
         ST_A: begin
            if (rx_done_tick) begin
               a_nx     = rx_data;
               state_nx = ST_B;
            end
         end
         ST_B: begin
            if (rx_done_tick) begin
               b_nx     = rx_data;
               state_nx = ST_OP;
            end
         end
         ST_OP: begin
            if (rx_done_tick) begin
               op_nx    = rx_data[N_OP-1:0];
               state_nx = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_nx          = alu_res;
            result_valid_nx = 1'b1;
            overrun_nx      = rx_done_tick;
            state_nx        = ST_SEND;
         end
         ST_SEND: begin
            tx_start_nx = 1'b1;
            tx_data_nx  = res_q;
            overrun_nx  = rx_done_tick;
            state_nx    = ST_WAIT;
         end
         ST_WAIT: begin
            // A byte arriving together with tx_done_tick is still dropped;
            // the command slot only reopens from the next cycle.
            overrun_nx = rx_done_tick;
            if (tx_done_tick) begin
               state_nx = ST_A;
            end
         end
         default: state_nx = ST_A;
      endcase

      // Registered from next state so busy rises the cycle after the opcode
      // and falls the cycle after tx_done_tick.
      busy_nx = (state_nx == ST_EXEC) || (state_nx == ST_SEND) ||
                (state_nx == ST_WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_A;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         res_q        <= '0;
         tx_data      <= '0;
         tx_start     <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nx;
         a_q          <= a_nx;
         b_q          <= b_nx;
         op_q         <= op_nx;
         res_q        <= res_nx;
         tx_data      <= tx_data_nx;
         tx_start     <= tx_start_nx;
         busy         <= busy_nx;
         result_valid <= result_valid_nx;
         overrun      <= overrun_nx;
      end
   end

endmodule
